// File: rtl/hawk_zline_comdecomp.sv
// Zero-line-elision page compressor and decompressor between the hawk read/write FIFOs.
// Compression drops all-zero cachelines; decompression re-inserts them from a bitmap.
module hawk_zline_comdecomp #(
  parameter int DATA_W     = 512,
  parameter int LINES      = 64,
  parameter int SIZE_W     = 14,
  parameter int INCOMP_MAX = 48
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                comp_start,
  input  logic                decomp_start,
  input  logic [LINES-1:0]    decomp_bitmap,
  output logic                busy,
  output logic                comp_done,
  output logic                decomp_done,
  output logic [SIZE_W-1:0]   comp_size,
  output logic [LINES-1:0]    comp_bitmap,
  output logic                incompressible,
  output logic                rd_err,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic [1:0]          rd_rresp,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_strb
);

  localparam int IDXW  = $clog2(LINES);
  localparam int LCW   = IDXW + 1;
  localparam int BYTES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, COMP, DECOMP, DONE} state_t;

  state_t              state_q, state_d;
  logic                mode_comp_q, mode_comp_d;
  logic [LCW-1:0]      line_cnt_q, line_cnt_d;
  logic [LCW-1:0]      nz_cnt_q, nz_cnt_d;
  logic [LINES-1:0]    bitmap_q, bitmap_d;
  logic [SIZE_W-1:0]   comp_size_q, comp_size_d;
  logic [LINES-1:0]    comp_bitmap_q, comp_bitmap_d;
  logic                incomp_q, incomp_d;
  logic                rd_err_q, rd_err_d;

  logic [IDXW-1:0]     line_idx;
  logic                line_zero;
  logic                step;
  logic                rresp_unused;

  assign line_idx     = line_cnt_q[IDXW-1:0];
  assign line_zero    = (rd_data == '0);
  assign rresp_unused = rd_rresp[0];

  always_comb begin
    state_d       = state_q;
    mode_comp_d   = mode_comp_q;
    line_cnt_d    = line_cnt_q;
    nz_cnt_d      = nz_cnt_q;
    bitmap_d      = bitmap_q;
    comp_size_d   = comp_size_q;
    comp_bitmap_d = comp_bitmap_q;
    incomp_d      = incomp_q;
    rd_err_d      = rd_err_q;
    rd_ready      = 1'b0;
    wr_valid      = 1'b0;
    wr_data       = '0;
    step          = 1'b0;

    case (state_q)
      IDLE: begin
        if (comp_start) begin
          state_d     = COMP;
          mode_comp_d = 1'b1;
          line_cnt_d  = '0;
          nz_cnt_d    = '0;
          rd_err_d    = 1'b0;
          bitmap_d    = '0;
        end else if (decomp_start) begin
          state_d     = DECOMP;
          mode_comp_d = 1'b0;
          line_cnt_d  = '0;
          nz_cnt_d    = '0;
          rd_err_d    = 1'b0;
          bitmap_d    = decomp_bitmap;
        end
      end
      COMP: begin
        // zero lines are swallowed even when the write FIFO is full
        rd_ready = (rd_valid && line_zero) || wr_ready;
        wr_valid = rd_valid && !line_zero;
        wr_data  = rd_data;
        if (rd_valid && rd_ready) begin
          step               = 1'b1;
          bitmap_d[line_idx] = line_zero;
          nz_cnt_d           = nz_cnt_q + {{(LCW-1){1'b0}}, !line_zero};
          if (rd_rresp[1]) rd_err_d = 1'b1;
        end
      end
      DECOMP: begin
        if (bitmap_q[line_idx]) begin
          wr_valid = 1'b1;
          step     = wr_ready;
        end else begin
          wr_valid = rd_valid;
          rd_ready = wr_ready;
          wr_data  = rd_data;
          if (rd_valid && wr_ready) begin
            step = 1'b1;
            if (rd_rresp[1]) rd_err_d = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (step) begin
      line_cnt_d = line_cnt_q + LCW'(1);
      if (line_cnt_q == LCW'(LINES - 1)) begin
        state_d = DONE;
        if (state_q == COMP) begin
          comp_size_d   = SIZE_W'(nz_cnt_d) * SIZE_W'(BYTES);
          comp_bitmap_d = bitmap_d;
          incomp_d      = (32'(nz_cnt_d) > INCOMP_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      mode_comp_q   <= 1'b0;
      line_cnt_q    <= '0;
      nz_cnt_q      <= '0;
      bitmap_q      <= '0;
      comp_size_q   <= '0;
      comp_bitmap_q <= '0;
      incomp_q      <= 1'b0;
      rd_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_comp_q   <= mode_comp_d;
      line_cnt_q    <= line_cnt_d;
      nz_cnt_q      <= nz_cnt_d;
      bitmap_q      <= bitmap_d;
      comp_size_q   <= comp_size_d;
      comp_bitmap_q <= comp_bitmap_d;
      incomp_q      <= incomp_d;
      rd_err_q      <= rd_err_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign comp_done      = (state_q == DONE) && mode_comp_q;
  assign decomp_done    = (state_q == DONE) && !mode_comp_q;
  assign comp_size      = comp_size_q;
  assign comp_bitmap    = comp_bitmap_q;
  assign incompressible = incomp_q;
  assign rd_err         = rd_err_q;
  assign wr_strb        = '1;

endmodule

// File: tb/tb_hawk_zline_comdecomp.sv
// Directed bench for hawk_zline_comdecomp: drives the read stream and sinks the write
// stream at the falling edge, comparing against hand-derived page results.
module tb_hawk_zline_comdecomp;

  localparam int DATA_W     = 512;
  localparam int LINES      = 64;
  localparam int SIZE_W     = 14;
  localparam int INCOMP_MAX = 48;

  logic                clk;
  logic                rst_i;
  logic                comp_start;
  logic                decomp_start;
  logic [LINES-1:0]    decomp_bitmap;
  logic                busy;
  logic                comp_done;
  logic                decomp_done;
  logic [SIZE_W-1:0]   comp_size;
  logic [LINES-1:0]    comp_bitmap;
  logic                incompressible;
  logic                rd_err;
  logic                rd_valid;
  logic                rd_ready;
  logic [DATA_W-1:0]   rd_data;
  logic [1:0]          rd_rresp;
  logic                wr_valid;
  logic                wr_ready;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_strb;

  hawk_zline_comdecomp #(
    .DATA_W(DATA_W), .LINES(LINES), .SIZE_W(SIZE_W), .INCOMP_MAX(INCOMP_MAX)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .comp_start(comp_start), .decomp_start(decomp_start), .decomp_bitmap(decomp_bitmap),
    .busy(busy), .comp_done(comp_done), .decomp_done(decomp_done),
    .comp_size(comp_size), .comp_bitmap(comp_bitmap), .incompressible(incompressible),
    .rd_err(rd_err), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_rresp(rd_rresp), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_strb(wr_strb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] src [LINES];
  logic [DATA_W-1:0] got [LINES];
  logic [DATA_W-1:0] exp_beats [LINES];
  int src_n, got_n, pops, done_cycle, cdone_n, ddone_n, zstall, err_line;
  logic [SIZE_W-1:0] res_size;
  logic [LINES-1:0]  res_bm;
  logic              res_inc, res_err, post_busy;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int i);
    pat = {32'hC0DE_0000 + 32'(i), 448'h0, 32'(i) + 32'h1};
  endfunction

  function automatic int count_mism(input int n);
    int m = 0;
    for (int i = 0; i < n && i < LINES; i++)
      if (got[i] !== exp_beats[i]) m++;
    return m;
  endfunction

  // Runs one operation from a falling edge; cycle 1 is the cycle after the start is sampled.
  task automatic applyStimulus(input bit cs, input bit ds, input logic [LINES-1:0] bm,
                               input bit stall, input int busy_start_at, input int stop_after);
    int ptr = 0;
    got_n = 0; pops = 0; done_cycle = -1; cdone_n = 0; ddone_n = 0; zstall = 0;
    post_busy = 1'b1;
    comp_start = cs; decomp_start = ds; decomp_bitmap = bm;
    rd_valid = 1'b0; wr_ready = 1'b1; rd_rresp = 2'b00;
    @(negedge clk);
    comp_start = 1'b0; decomp_start = 1'b0; decomp_bitmap = '0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      comp_start   = (cyc == busy_start_at);
      decomp_start = (cyc == busy_start_at);
      rd_valid = (ptr < src_n);
      rd_data  = (ptr < src_n) ? src[ptr] : '0;
      rd_rresp = (ptr == err_line) ? 2'b10 : 2'b00;
      wr_ready = stall ? (cyc % 3 != 0) : 1'b1;
      #1;
      if (comp_done) cdone_n++;
      if (decomp_done) ddone_n++;
      if ((comp_done || decomp_done) && done_cycle < 0) begin
        done_cycle = cyc;
        res_size = comp_size; res_bm = comp_bitmap; res_inc = incompressible; res_err = rd_err;
      end
      if (wr_valid && wr_ready) begin
        if (got_n < LINES) got[got_n] = wr_data;
        got_n++;
      end
      if (rd_valid && rd_ready) begin
        if (cs && rd_data == '0 && !wr_ready) zstall++;
        ptr++;
        pops++;
      end
      if (done_cycle > 0 && cyc > done_cycle) begin
        post_busy = busy;
        break;
      end
      @(negedge clk);
      if (cyc == stop_after) return;
    end
    @(negedge clk);
    rd_valid = 1'b0; rd_rresp = 2'b00; wr_ready = 1'b1;
    comp_start = 1'b0; decomp_start = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; comp_start = 1'b0; decomp_start = 1'b0; decomp_bitmap = '0;
    rd_valid = 1'b0; rd_data = '0; rd_rresp = 2'b00; wr_ready = 1'b1;
    err_line = -1; src_n = 0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", {comp_done, decomp_done}, 0);
    checkOutput("rst_size", comp_size, 0);
    checkOutput("rst_bitmap", comp_bitmap, 0);
    checkOutput("rst_incomp", incompressible, 0);
    checkOutput("rst_rd_err", rd_err, 0);
    checkOutput("rst_handshake", {rd_ready, wr_valid}, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("wr_strb", wr_strb, {(DATA_W/8){1'b1}});
    rst_i = 1'b0;
    @(negedge clk);

    $display("[TB] compress, all lines non-zero");
    for (int i = 0; i < LINES; i++) begin src[i] = pat(i); exp_beats[i] = pat(i); end
    src_n = LINES;
    applyStimulus(1'b1, 1'b0, '0, 1'b0, -1, -1);
    checkOutput("c1_done_cycle", done_cycle, 65);
    checkOutput("c1_beats", got_n, 64);
    checkOutput("c1_data", count_mism(got_n), 0);
    checkOutput("c1_pops", pops, 64);
    checkOutput("c1_size", res_size, 4096);
    checkOutput("c1_bitmap", res_bm, 0);
    checkOutput("c1_incomp", res_inc, 1);
    checkOutput("c1_pulses", {cdone_n[3:0], ddone_n[3:0]}, 8'h10);
    checkOutput("c1_idle_after", post_busy, 0);

    $display("[TB] compress, even lines zero");
    for (int i = 0; i < LINES; i++) src[i] = (i % 2 == 1) ? pat(i) : '0;
    for (int k = 0; k < 32; k++) exp_beats[k] = pat(2 * k + 1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, -1, -1);
    checkOutput("c2_done_cycle", done_cycle, 65);
    checkOutput("c2_beats", got_n, 32);
    checkOutput("c2_data", count_mism(got_n), 0);
    checkOutput("c2_size", res_size, 2048);
    checkOutput("c2_bitmap", res_bm, 64'h5555_5555_5555_5555);
    checkOutput("c2_incomp", res_inc, 0);

    $display("[TB] compress 49 non-zero lines with write backpressure");
    for (int i = 0; i < LINES; i++) begin src[i] = (i < 49) ? pat(i) : '0; exp_beats[i] = pat(i); end
    applyStimulus(1'b1, 1'b0, '0, 1'b1, -1, -1);
    checkOutput("c3_done_cycle", done_cycle, 89);
    checkOutput("c3_beats", got_n, 49);
    checkOutput("c3_data", count_mism(got_n), 0);
    checkOutput("c3_size", res_size, 3136);
    checkOutput("c3_bitmap", res_bm, 64'hFFFE_0000_0000_0000);
    checkOutput("c3_incomp", res_inc, 1);
    checkOutput("c3_zero_stall_pops", zstall, 5);

    $display("[TB] compress 48 non-zero lines with write backpressure");
    for (int i = 0; i < LINES; i++) src[i] = (i < 48) ? pat(i) : '0;
    applyStimulus(1'b1, 1'b0, '0, 1'b1, -1, -1);
    checkOutput("c4_done_cycle", done_cycle, 88);
    checkOutput("c4_beats", got_n, 48);
    checkOutput("c4_data", count_mism(got_n), 0);
    checkOutput("c4_size", res_size, 3072);
    checkOutput("c4_bitmap", res_bm, 64'hFFFF_0000_0000_0000);
    checkOutput("c4_incomp", res_inc, 0);
    checkOutput("c4_zero_stall_pops", zstall, 6);

    $display("[TB] decompress, even lines zero");
    for (int k = 0; k < 32; k++) src[k] = pat(100 + k);
    src_n = 32;
    for (int i = 0; i < LINES; i++) exp_beats[i] = (i % 2 == 1) ? pat(100 + (i - 1) / 2) : '0;
    applyStimulus(1'b0, 1'b1, 64'h5555_5555_5555_5555, 1'b0, -1, -1);
    checkOutput("d1_done_cycle", done_cycle, 65);
    checkOutput("d1_beats", got_n, 64);
    checkOutput("d1_data", count_mism(got_n), 0);
    checkOutput("d1_pops", pops, 32);
    checkOutput("d1_pulses", {cdone_n[3:0], ddone_n[3:0]}, 8'h01);
    checkOutput("d1_size_kept", comp_size, 3072);
    checkOutput("d1_bitmap_kept", comp_bitmap, 64'hFFFF_0000_0000_0000);

    $display("[TB] simultaneous starts, start while busy, read error on line 5");
    for (int i = 0; i < LINES; i++) begin src[i] = pat(i); exp_beats[i] = pat(i); end
    src_n = LINES;
    err_line = 5;
    applyStimulus(1'b1, 1'b1, '1, 1'b0, 10, -1);
    checkOutput("s1_done_cycle", done_cycle, 65);
    checkOutput("s1_pulses", {cdone_n[3:0], ddone_n[3:0]}, 8'h10);
    checkOutput("s1_beats", got_n, 64);
    checkOutput("s1_data", count_mism(got_n), 0);
    checkOutput("s1_size", res_size, 4096);
    checkOutput("s1_rd_err", res_err, 1);
    err_line = -1;

    $display("[TB] decompress all-zero page");
    src_n = 0;
    for (int i = 0; i < LINES; i++) exp_beats[i] = '0;
    applyStimulus(1'b0, 1'b1, '1, 1'b0, -1, -1);
    checkOutput("d2_done_cycle", done_cycle, 65);
    checkOutput("d2_beats", got_n, 64);
    checkOutput("d2_data", count_mism(got_n), 0);
    checkOutput("d2_pops", pops, 0);
    checkOutput("d2_rd_err_cleared", res_err, 0);

    $display("[TB] reset during compression");
    for (int i = 0; i < LINES; i++) src[i] = pat(i);
    src_n = LINES;
    applyStimulus(1'b1, 1'b0, '0, 1'b0, -1, 21);
    checkOutput("r1_pops_before", pops, 21);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    checkOutput("r1_busy", busy, 0);
    checkOutput("r1_handshake", {rd_ready, wr_valid}, 0);
    checkOutput("r1_done", {comp_done, decomp_done, cdone_n[3:0]}, 0);
    checkOutput("r1_results", {comp_size, comp_bitmap, incompressible, rd_err}, 0);
    @(negedge clk);

    $display("[TB] compress after reset, every fourth line zero");
    for (int i = 0; i < LINES; i++) src[i] = (i % 4 == 0) ? '0 : pat(i);
    for (int k = 0; k < 48; k++) exp_beats[k] = pat(k + k / 3 + 1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, -1, -1);
    checkOutput("c5_done_cycle", done_cycle, 65);
    checkOutput("c5_beats", got_n, 48);
    checkOutput("c5_data", count_mism(got_n), 0);
    checkOutput("c5_size", res_size, 3072);
    checkOutput("c5_bitmap", res_bm, 64'h1111_1111_1111_1111);
    checkOutput("c5_incomp", res_inc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hawk_zline_comdecomp.md
# hawk_zline_comdecomp

Parametrised successor to the page compression/decompression unit in the hawk chipset path. It performs zero-line-elision compression and, unlike its predecessor, real decompression. Compression consumes one page from the read FIFO stream, drops all-zero cachelines, forwards non-zero lines to the write FIFO stream, and reports a zero-line bitmap, compressed size and incompressibility verdict. Decompression takes a bitmap plus a packed stream and regenerates the full page. It sits between the hawk read/write FIFOs and the page-management FSM.

## Interface
- DATA_W, 512, bits per cacheline beat; must be a multiple of 8.
- LINES, 64, cachelines per page; LINES <= DATA_W, LINES >= 2.
- SIZE_W, 14, width of comp_size; LINES*DATA_W/8 < 2**SIZE_W.
- INCOMP_MAX, 48, maximum non-zero line count still treated as compressible.
- clk_i  in  1  clock.
- rst_i  in  1  reset: one clock; reset is synchronous and active-high.
- comp_start  in  1  start compression; sampled only in IDLE.
- decomp_start  in  1  start decompression; sampled only in IDLE.
- decomp_bitmap  in  LINES  zero-line bitmap, sampled with decomp_start; bit i=1 means line i is zero.
- busy  out  1  high in any state other than IDLE.
- comp_done  out  1  one-cycle pulse at the end of compression.
- decomp_done  out  1  one-cycle pulse at the end of decompression.
- comp_size  out  SIZE_W  compressed bytes, i.e. non-zero lines * DATA_W/8.
- comp_bitmap  out  LINES  zero-line bitmap of the last compressed page.
- incompressible  out  1  non-zero line count > INCOMP_MAX.
- rd_err  out  1  sticky; set if any accepted beat had rd_rresp[1]=1.
- rd_valid  in  1  read stream beat valid (read FIFO not empty).
- rd_ready  out  1  read stream pop.
- rd_data  in  DATA_W  read beat.
- rd_rresp  in  2  AXI response of the beat.
- wr_valid  out  1  write stream push.
- wr_ready  in  1  write FIFO not full.
- wr_data  out  DATA_W  write beat.
- wr_strb  out  DATA_W/8  always all ones.

## Operation
- States: IDLE, COMP, DECOMP, DONE. line_cnt is $clog2(LINES)+1 bits. nz_cnt is $clog2(LINES)+1 bits. bitmap register is LINES bits.
- IDLE: if comp_start, go to COMP. Otherwise, if decomp_start, go to DECOMP and latch decomp_bitmap. comp_start has priority when both are asserted.
- On any start: clear line_cnt, nz_cnt and rd_err. On comp_start, also clear the bitmap register.
- Starts while busy are ignored.
- COMP:
  - line is zero when rd_data == 0.
  - rd_ready = rd_valid_zero ? 1 : wr_ready. Zero lines never stall on a full write FIFO.
  - wr_valid = rd_valid && !zero. wr_data = rd_data (combinational pass-through).
  - On each rd handshake: bitmap[line_cnt] = zero; nz_cnt += !zero; line_cnt += 1.
- DECOMP:
  - If bitmap[line_cnt] is set: wr_valid=1, wr_data=0, rd_ready=0. Advance line_cnt on wr_ready.
  - Otherwise: wr_valid=rd_valid, rd_ready=wr_ready, wr_data=rd_data. Advance line_cnt on the handshake.
- Exit from COMP or DECOMP: when the handshake of line LINES-1 occurs, go to DONE.
- DONE (one cycle): pulse comp_done or decomp_done according to the originating mode, then go to IDLE.
- On exit from COMP, register these results:
  - comp_size = nz_cnt*(DATA_W/8), zero-extended to SIZE_W.
  - comp_bitmap = the bitmap register.
  - incompressible = (nz_cnt > INCOMP_MAX).
- comp_size, comp_bitmap and incompressible hold until the next comp_start completes. decomp does not alter them.
- rd_err is set when rd_valid && rd_ready && rd_rresp[1]. Processing continues, and the beat is treated as data.
- rd_ready and wr_valid are 0 in IDLE and DONE.
- Reset: state=IDLE. All outputs are 0: busy, done pulses, comp_size, comp_bitmap, incompressible, rd_err, rd_ready, wr_valid, wr_data.
- Reset mid-operation aborts the operation with no done pulse. Partial beats already pushed stay in the FIFO; the caller flushes them.

## Timing
- Start seen in cycle t: busy=1 from t+1. The first rd_ready/wr_valid is possible at t+1.
- With rd_valid=wr_ready=1 continuously, there is one line per cycle. The last handshake is at t+LINES, the done pulse at t+LINES+1, and IDLE (ready for a new start) at t+LINES+2.
- Result registers are valid in the same cycle as comp_done.
- Decompression of an all-zero bitmap needs no rd traffic: LINES cycles when wr_ready=1.
- Backpressure: each deasserted wr_ready or rd_valid cycle stretches the operation by exactly one cycle. Exception: a zero line in COMP proceeds even with wr_ready=0.
- Combinational paths rd_data->wr_data, rd_valid->wr_valid and wr_ready->rd_ready exist. The surrounding FIFOs must have registered outputs.

## Test plan
- Compress, all lines non-zero, no stalls (LINES=64, DATA_W=512): 64 wr beats equal to the inputs, comp_size=4096, comp_bitmap=0, incompressible=1, comp_done at t+65.
- Compress, even lines zero: 32 wr beats (odd lines, in order), comp_size=2048, comp_bitmap=64'h5555_5555_5555_5555, incompressible=0.
- Compress 49 vs 48 non-zero lines: incompressible=1 and 0 respectively. Random wr_ready=0 cycles must still produce the same results; zero lines are consumed while wr_ready=0.
- Decompress with decomp_bitmap=64'h5555_5555_5555_5555 and 32 packed beats: 64 wr beats, where even beats=0 and odd beats equal the packed data in order. Exactly 32 rd pops, then the decomp_done pulse.
- Simultaneous comp_start and decomp_start: COMP runs and only comp_done pulses. A start during busy is ignored. rd_rresp=2'b10 on line 5: rd_err=1 at the end, and it clears on the next start.
- rst_i asserted after line 20 of a compression: next cycle busy=0, rd_ready=wr_valid=0, results=0, no done pulse. A following full compression is correct.
